// File: rtl/mem_access_stage.sv
// Purpose : MEM stage; ALU results pass straight through, LDUR/STUR/LDURB/STURB go to data memory via req/ack.
// Latency : ALU ops 0 cycles (combinational); memory ops occupy k+2 cycles for an ack in the k-th REQ cycle.
// Backpr. : stall freezes upstream while an access is pending; a bubble (control_out=0) goes to MEM/WB meanwhile.
//
// Ports: clk/reset (sync, active-high); EX/MEM entry in (in_valid, Rd_in, alu_in, sdata_in, mem_read,
//        mem_write, byte_op, reg_write_in); stall to upstream; data-memory bus (mem_req, mem_we, mem_addr,
//        mem_wdata, mem_be, mem_rdata, mem_ack); MEM/WB out (Rd_out, Dw_out, control_out); fault pulse.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [4:0]  Rd_in,
    input  logic [63:0] alu_in,
    input  logic [63:0] sdata_in,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_op,
    input  logic        reg_write_in,
    output logic        stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_be,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ack,
    output logic [4:0]  Rd_out,
    output logic [63:0] Dw_out,
    output logic        control_out,
    output logic        fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Wide enough to hold TIMEOUT itself so the increment never wraps.
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    rd_q, rd_d;
    logic [63:0]   addr_q, addr_d;
    logic [63:0]   sdata_q, sdata_d;
    logic [63:0]   ldata_q, ldata_d;
    logic          rd_op_q, rd_op_d;
    logic          wr_op_q, wr_op_d;
    logic          byte_q, byte_d;
    logic          rw_q, rw_d;
    logic          tmo_q, tmo_d;
    logic          post_rst_q, post_rst_d;

    logic          vld;
    logic          mem_op;
    logic          bad;
    logic          timeout_hit;
    logic [2:0]    lane;

    always_comb begin
        // The cycle right after reset is kept quiet: the entry shown is treated as empty.
        vld         = in_valid & ~reset & ~post_rst_q;
        mem_op      = vld & (mem_read | mem_write);
        bad         = (mem_read & mem_write) | (~byte_op & (alu_in[2:0] != 3'b000));
        timeout_hit = (cnt_q == CW'(TIMEOUT - 1));
        lane        = addr_q[2:0];

        state_d    = state_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        ldata_d    = ldata_q;
        rd_op_d    = rd_op_q;
        wr_op_d    = wr_op_q;
        byte_d     = byte_q;
        rw_d       = rw_q;
        tmo_d      = tmo_q;
        post_rst_d = 1'b0;

        stall       = 1'b0;
        mem_req     = 1'b0;
        fault       = 1'b0;
        control_out = 1'b0;
        Rd_out      = Rd_in;
        Dw_out      = alu_in;

        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    if (bad) begin
                        // Dropped: no request, no writeback, upstream keeps moving.
                        fault = 1'b1;
                    end else begin
                        rd_d    = Rd_in;
                        addr_d  = alu_in;
                        sdata_d = sdata_in;
                        rd_op_d = mem_read;
                        wr_op_d = mem_write;
                        byte_d  = byte_op;
                        rw_d    = reg_write_in;
                        cnt_d   = '0;
                        tmo_d   = 1'b0;
                        state_d = S_REQ;
                        stall   = 1'b1;
                    end
                end else begin
                    control_out = vld & reg_write_in;
                end
            end
            S_REQ: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (mem_ack) begin
                    ldata_d = byte_q ? {56'b0, mem_rdata[{lane, 3'b000} +: 8]} : mem_rdata;
                    state_d = S_DONE;
                end else if (timeout_hit) begin
                    fault   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // EX/MEM still shows the completed instruction, so inputs are not looked at.
                Rd_out      = rd_q;
                Dw_out      = rd_op_q ? ldata_q : addr_q;
                control_out = rw_q & ~tmo_q & ~wr_op_q;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (reset) begin
            stall       = 1'b0;
            mem_req     = 1'b0;
            fault       = 1'b0;
            control_out = 1'b0;
        end
    end

    // Bus fields come straight from the capture registers, so they hold steady through REQ.
    assign mem_we    = mem_req & wr_op_q;
    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_be    = byte_q ? (8'h01 << lane) : 8'hFF;
    assign mem_wdata = byte_q ? {8{sdata_q[7:0]}} : sdata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            rd_q       <= '0;
            addr_q     <= '0;
            sdata_q    <= '0;
            ldata_q    <= '0;
            rd_op_q    <= 1'b0;
            wr_op_q    <= 1'b0;
            byte_q     <= 1'b0;
            rw_q       <= 1'b0;
            tmo_q      <= 1'b0;
            post_rst_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            ldata_q    <= ldata_d;
            rd_op_q    <= rd_op_d;
            wr_op_q    <= wr_op_d;
            byte_q     <= byte_d;
            rw_q       <= rw_d;
            tmo_q      <= tmo_d;
            post_rst_q <= post_rst_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Purpose : self-checking bench for mem_access_stage with a byte-addressed memory reference model.
// Latency : expectations are queued at issue and popped on each cycle the stage retires an entry.
// Backpr. : the driver holds each entry while stall is high, bounded by a cycle budget.
module tb_mem_access_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [4:0]  Rd_in;
    logic [63:0] alu_in, sdata_in;
    logic        mem_read, mem_write, byte_op, reg_write_in;
    logic        stall, mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_be;
    logic        mem_ack;
    logic [4:0]  Rd_out;
    logic [63:0] Dw_out;
    logic        control_out, fault;

    mem_access_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .Rd_in(Rd_in), .alu_in(alu_in),
        .sdata_in(sdata_in), .mem_read(mem_read), .mem_write(mem_write), .byte_op(byte_op),
        .reg_write_in(reg_write_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .Rd_out(Rd_out), .Dw_out(Dw_out), .control_out(control_out),
        .fault(fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] dw;
        logic        cw;
        int          faults;
        int          stalls;
        bit          chk_rd;
        bit          chk_dw;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ref_mem[longint];
    logic [7:0]  bus_mem[longint];

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    bit          force_ack = 1'b0;
    int          ack_at = 0;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_be;
    logic        exp_we;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [7:0] init_byte(input longint a);
        return 8'(a * 37) ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ref_rd(input longint a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] bus_rd(input longint a);
        return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
    endfunction

    task automatic preload(input longint a, input logic [63:0] v);
        for (int i = 0; i < 8; i++) begin
            ref_mem[a + i] = v[8*i +: 8];
            bus_mem[a + i] = v[8*i +: 8];
        end
    endtask

    // Memory responder: acks in the ack_at-th REQ cycle, sprinkles junk acks when idle.
    int req_cnt = 0;
    always @(posedge clk) begin
        #1;
        if (mem_req) begin
            req_cnt++;
            if (req_cnt == ack_at) begin
                mem_ack = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    mem_rdata[8*i +: 8] = bus_rd(longint'(mem_addr) + i);
                    if (mem_we && mem_be[i])
                        bus_mem[longint'(mem_addr) + i] = mem_wdata[8*i +: 8];
                end
            end else begin
                mem_ack = 1'b0;
            end
        end else begin
            req_cnt   = 0;
            mem_ack   = force_ack | ($urandom_range(0, 3) == 0);
            mem_rdata = {$urandom, $urandom};
        end
    end

    // Monitor: checks bus fields in every REQ cycle and retires one expectation per non-stall cycle.
    int   stall_cnt = 0;
    int   flt_cnt = 0;
    exp_t me;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (mem_req) begin
                chk("req_addr", mem_addr, exp_addr);
                chk("req_be", 64'(mem_be), 64'(exp_be));
                chk("req_wdata", mem_wdata, exp_wdata);
                chk("req_we", 64'(mem_we), 64'(exp_we));
            end
            if (fault) flt_cnt++;
            if (stall) begin
                stall_cnt++;
            end else if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: retire with empty queue (t=%0t)", $time);
            end else begin
                me = exp_q.pop_front();
                chk("control_out", 64'(control_out), 64'(me.cw));
                chk("fault_pulses", 64'(flt_cnt), 64'(me.faults));
                chk("stall_cycles", 64'(stall_cnt), 64'(me.stalls));
                if (me.chk_rd) chk("Rd_out", 64'(Rd_out), 64'(me.rd));
                if (me.chk_dw) chk("Dw_out", Dw_out, me.dw);
                flt_cnt   = 0;
                stall_cnt = 0;
            end
        end
    end

    // Present one EX/MEM entry (called at posedge+1), queue its outcome, hold it until retired.
    task automatic issue(input logic v, input logic [4:0] rd, input logic [63:0] a,
                         input logic [63:0] sd, input logic mr, input logic mw,
                         input logic bop, input logic rw, input int k);
        exp_t e;
        bit   tmo;
        int   guard;
        in_valid = v; Rd_in = rd; alu_in = a; sdata_in = sd;
        mem_read = mr; mem_write = mw; byte_op = bop; reg_write_in = rw;
        e.rd = rd; e.dw = a; e.cw = 1'b0; e.faults = 0; e.stalls = 0;
        e.chk_rd = 1'b1; e.chk_dw = 1'b1;
        if (!(v && (mr || mw))) begin
            e.cw = v && rw;
        end else if ((mr && mw) || (!bop && a[2:0] != 3'b000)) begin
            e.faults = 1; e.chk_rd = 1'b0; e.chk_dw = 1'b0;
        end else begin
            tmo       = (k > TMO);
            e.stalls  = tmo ? TMO + 1 : k + 1;
            e.faults  = tmo ? 1 : 0;
            exp_addr  = a & ~64'd7;
            exp_we    = mw;
            exp_be    = bop ? (8'h01 << a[2:0]) : 8'hFF;
            exp_wdata = bop ? {8{sd[7:0]}} : sd;
            ack_at    = k;
            if (tmo) begin
                e.chk_dw = 1'b0;
            end else if (mw) begin
                if (bop) ref_mem[longint'(a)] = sd[7:0];
                else for (int i = 0; i < 8; i++) ref_mem[longint'(a) + i] = sd[8*i +: 8];
            end else begin
                e.cw = rw;
                if (bop) e.dw = {56'b0, ref_rd(longint'(a))};
                else for (int i = 0; i < 8; i++) e.dw[8*i +: 8] = ref_rd(longint'(a) + i);
            end
        end
        exp_q.push_back(e);
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (stall && guard < 50);
        if (stall) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: stall still high after %0d cycles", guard);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] a;
        int          kind, k;
        reset = 1'b1; in_valid = 1'b1; Rd_in = 5'd3; alu_in = 64'h55; sdata_in = '0;
        mem_read = 1'b0; mem_write = 1'b0; byte_op = 1'b0; reg_write_in = 1'b1;
        mem_ack = 1'b0; mem_rdata = '0;
        exp_addr = '0; exp_wdata = '0; exp_be = '0; exp_we = 1'b0;

        // Outputs quiet while reset is high and in the first cycle after, even with an ALU op shown.
        repeat (2) begin
            @(negedge clk);
            chk("rst_stall", 64'(stall), 64'd0);
            chk("rst_req", 64'(mem_req), 64'd0);
            chk("rst_fault", 64'(fault), 64'd0);
            chk("rst_ctrl", 64'(control_out), 64'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ctrl", 64'(control_out), 64'd0);
        chk("post_rst_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed cases.
        issue(1, 5'd5, 64'h1234, 0, 0, 0, 0, 1, 0);
        preload(64'h100, 64'hDEADBEEF_CAFEF00D);
        issue(1, 5'd9, 64'h100, 0, 1, 0, 0, 1, 3);
        issue(1, 5'd2, 64'h10B, 64'h1111_2222_3333_44AB, 0, 1, 1, 1, 2);
        preload(64'h100, 64'h0011223344556677);
        issue(1, 5'd4, 64'h105, 0, 1, 0, 1, 1, 1);
        issue(1, 5'd6, 64'h104, 0, 1, 0, 0, 1, 1);
        issue(1, 5'd7, 64'h100, 0, 1, 0, 0, 1, TMO + 10);
        issue(1, 5'd8, 64'h108, 0, 1, 0, 0, 1, TMO);
        issue(1, 5'd1, 64'h0, 0, 1, 1, 1, 1, 1);

        // Random mix over a small address window so stores and loads overlap.
        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 7);
            k    = $urandom_range(1, TMO + 1);
            a    = 64'h100 + 64'($urandom_range(0, 63));
            case (kind)
                0: issue(1, 5'($urandom), {$urandom, $urandom}, 0, 0, 0, 1'($urandom), 1'($urandom), 0);
                1: issue(0, 5'($urandom), {$urandom, $urandom}, 0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), k);
                2: issue(1, 5'($urandom), a & ~64'd7, 0, 1, 0, 0, 1'($urandom), k);
                3: issue(1, 5'($urandom), a & ~64'd7, {$urandom, $urandom}, 0, 1, 0, 1'($urandom), k);
                4: issue(1, 5'($urandom), a, 0, 1, 0, 1, 1'($urandom), k);
                5: issue(1, 5'($urandom), a, {$urandom, $urandom}, 0, 1, 1, 1'($urandom), k);
                6: issue(1, 5'($urandom), a | 64'd1, 0, 1'($urandom), 1, 0, 1, k);
                default: issue(1, 5'($urandom), a, 0, 1, 1, 1'($urandom), 1, k);
            endcase
        end
        mon_en = 1'b0;
        in_valid = 1'b0;
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        // Reset in the 2nd REQ cycle of a load that never gets acked.
        ack_at = 1000;
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; byte_op = 1'b0;
        alu_in = 64'h100; Rd_in = 5'd3; reg_write_in = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("req1_req", 64'(mem_req), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_req", 64'(mem_req), 64'd0);
        chk("rst_mid_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0; force_ack = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
        @(negedge clk);
        chk("after_rst_req", 64'(mem_req), 64'd0);
        chk("after_rst_stall", 64'(stall), 64'd0);
        chk("after_rst_ctrl", 64'(control_out), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b1; Rd_in = 5'd7; alu_in = 64'hABC; reg_write_in = 1'b1;
        @(negedge clk);
        chk("alu_after_rst_rd", 64'(Rd_out), 64'd7);
        chk("alu_after_rst_dw", Dw_out, 64'hABC);
        chk("alu_after_rst_ctrl", 64'(control_out), 64'd1);
        chk("alu_after_rst_stall", 64'(stall), 64'd0);
        chk("alu_after_rst_req", 64'(mem_req), 64'd0);
        @(posedge clk); #1;
        force_ack = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
